mtr_drv: RTL and testbench

Motor-drive back end of the Segway control path. Consumes the signed 12-bit `lft_spd`/`rght_spd` commands produced by balance control and converts each into a complementary pair of H-bridge PWM signals. Each pair has non-overlap dead time and a duty update synchronized to the PWM period. Repeated over-current faults latch a shutdown that forces all bridge outputs low.

---
 rtl/mtr_drv.sv | 183 ++++++++++++++++++
 tb/tb_mtr_drv.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mtr_drv.sv
`default_nettype none
// ============================================================================
//  Module   : mtr_drv
//  Purpose  : Motor-drive back end. Converts signed 12-bit left/right speed
//             commands into complementary H-bridge PWM pairs with dead time,
//             period-synchronous duty updates and a latched over-current
//             shutdown.
//  Ports    : clk, rst        - 50 MHz clock, synchronous active-high reset
//             lft_spd         - signed left speed command
//             rght_spd        - signed right speed command
//             OVR_I_lft/rght  - bridge over-current comparators (active high)
//             PWM1_*/PWM2_*   - high/low drive of each bridge
//             PWM_synch       - one-cycle pulse on the last cycle of a period
//             OVR_I_shtdwn    - sticky over-current shutdown
//  Revision : 1.0  initial release
// ============================================================================
module mtr_drv #(
    parameter int NONOVERLAP = 32,   // dead-time cycles (1..255)
    parameter int BLANK      = 128,  // over-current blanking after PWM edges
    parameter int OVR_LIMIT  = 4     // consecutive faulted periods (1..15)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_spd,
    input  logic [11:0] rght_spd,
    input  logic        OVR_I_lft,
    input  logic        OVR_I_rght,
    output logic        PWM1_lft,
    output logic        PWM2_lft,
    output logic        PWM1_rght,
    output logic        PWM2_rght,
    output logic        PWM_synch,
    output logic        OVR_I_shtdwn
);

    localparam int                 BLANK_W      = $clog2(BLANK + 1);
    localparam logic [7:0]         NONOVERLAP_C = 8'(NONOVERLAP);
    localparam logic [BLANK_W-1:0] BLANK_C      = BLANK_W'(BLANK);
    localparam logic [BLANK_W-1:0] BLANK_ONE    = BLANK_W'(1);
    localparam logic [3:0]         OVR_LIMIT_C  = 4'(OVR_LIMIT);

    // ------------------------------------------------------------------
    // Shared period counter
    // ------------------------------------------------------------------
    logic [10:0] cnt;
    logic        synch;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end

    assign synch     = (cnt == 11'h7FF);
    assign PWM_synch = synch;

    // ------------------------------------------------------------------
    // Per-motor channel: duty mapping, raw PWM, dead time, blanking
    // ------------------------------------------------------------------
    logic [11:0] spd [2];
    logic [1:0]  pwm1_raw;
    logic [1:0]  pwm2_raw;
    logic [1:0]  blank_done;

    assign spd[0] = lft_spd;
    assign spd[1] = rght_spd;

    for (genvar m = 0; m < 2; m++) begin : g_motor
        logic signed [12:0]   sum;
        logic [10:0]          duty;
        logic [10:0]          duty_q;
        logic                 pwm_sig;
        logic                 pwm_prev;
        logic                 changed;
        logic [7:0]           dead_tmr;
        logic [BLANK_W-1:0]   blank_cnt;
        logic                 pwm1_q;
        logic                 pwm2_q;

        // Offset into 0..2047; bit 12 flags underflow, bit 11 overflow.
        always_comb begin
            sum = $signed({spd[m][11], spd[m]}) + 13'sd1024;
            if (sum[12]) begin
                duty = '0;
            end else if (sum[11]) begin
                duty = 11'h7FF;
            end else begin
                duty = sum[10:0];
            end
        end

        // An edge of pwm_sig is seen one cycle later via pwm_prev; that
        // cycle both drives drop and the dead timer restarts at 1 so the
        // new drive rises NONOVERLAP+1 cycles after the pwm_sig edge.
        assign changed = pwm_sig ^ pwm_prev;

        always_ff @(posedge clk) begin
            if (rst) begin
                duty_q    <= 11'h400;
                pwm_sig   <= 1'b0;
                pwm_prev  <= 1'b0;
                dead_tmr  <= '0;
                pwm1_q    <= 1'b0;
                pwm2_q    <= 1'b0;
                blank_cnt <= '0;
            end else begin
                if (synch) begin
                    duty_q <= duty;
                end
                pwm_sig  <= (cnt < duty_q);
                pwm_prev <= pwm_sig;

                if (changed) begin
                    dead_tmr <= 8'd1;
                    pwm1_q   <= 1'b0;
                    pwm2_q   <= 1'b0;
                end else if (dead_tmr == NONOVERLAP_C) begin
                    pwm1_q   <= pwm_sig;
                    pwm2_q   <= ~pwm_sig;
                end else begin
                    dead_tmr <= dead_tmr + 8'd1;
                end

                if (changed) begin
                    blank_cnt <= '0;
                end else if (blank_cnt != BLANK_C) begin
                    blank_cnt <= blank_cnt + BLANK_ONE;
                end
            end
        end

        assign pwm1_raw[m]   = pwm1_q;
        assign pwm2_raw[m]   = pwm2_q;
        assign blank_done[m] = (blank_cnt == BLANK_C);
    end

    // ------------------------------------------------------------------
    // Over-current qualification and shutdown
    // ------------------------------------------------------------------
    logic       fault_now;
    logic       fault_flag;
    logic [3:0] fault_cnt;
    logic       shtdwn;

    assign fault_now = (OVR_I_lft | OVR_I_rght) & (|blank_done);

    // A fault seen on the synch cycle itself belongs to the ending period,
    // hence the OR with fault_now when the period is closed.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_flag <= 1'b0;
            fault_cnt  <= '0;
            shtdwn     <= 1'b0;
        end else if (synch) begin
            fault_flag <= 1'b0;
            if (fault_flag | fault_now) begin
                if (fault_cnt != OVR_LIMIT_C) begin
                    fault_cnt <= fault_cnt + 4'd1;
                end
                if (fault_cnt >= OVR_LIMIT_C - 4'd1) begin
                    shtdwn <= 1'b1;
                end
            end else begin
                fault_cnt <= '0;
            end
        end else if (fault_now) begin
            fault_flag <= 1'b1;
        end
    end

    assign OVR_I_shtdwn = shtdwn;

    // Gating after the registers lets shutdown kill the drives on the
    // same edge that sets it.
    assign PWM1_lft  = pwm1_raw[0] & ~shtdwn;
    assign PWM2_lft  = pwm2_raw[0] & ~shtdwn;
    assign PWM1_rght = pwm1_raw[1] & ~shtdwn;
    assign PWM2_rght = pwm2_raw[1] & ~shtdwn;

endmodule
`default_nettype wire

// File: tb/tb_mtr_drv.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mtr_drv
//  Purpose  : Directed self-checking bench for mtr_drv: reset, mid-scale and
//             clipped duty, synchronized duty update, over-current shutdown,
//             blanking and reset out of shutdown.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_mtr_drv;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] lft_spd;
    logic [11:0] rght_spd;
    logic        OVR_I_lft;
    logic        OVR_I_rght;
    logic        PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght;
    logic        PWM_synch, OVR_I_shtdwn;

    mtr_drv #(.NONOVERLAP(32), .BLANK(128), .OVR_LIMIT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .lft_spd      (lft_spd),
        .rght_spd     (rght_spd),
        .OVR_I_lft    (OVR_I_lft),
        .OVR_I_rght   (OVR_I_rght),
        .PWM1_lft     (PWM1_lft),
        .PWM2_lft     (PWM2_lft),
        .PWM1_rght    (PWM1_rght),
        .PWM2_rght    (PWM2_rght),
        .PWM_synch    (PWM_synch),
        .OVR_I_shtdwn (OVR_I_shtdwn)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int overlap  = 0;
    int n_p1l, n_p2l, n_p1r, n_p2r, n_lowl, n_synch;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_p1l = 0; n_p2l = 0; n_p1r = 0; n_p2r = 0; n_lowl = 0; n_synch = 0;
    endtask

    task automatic sample();
        if (PWM1_lft)  n_p1l++;
        if (PWM2_lft)  n_p2l++;
        if (PWM1_rght) n_p1r++;
        if (PWM2_rght) n_p2r++;
        if (!PWM1_lft && !PWM2_lft) n_lowl++;
        if (PWM_synch) n_synch++;
        if (PWM1_lft && PWM2_lft)   overlap++;
        if (PWM1_rght && PWM2_rght) overlap++;
    endtask

    // First period after reset release: sample i is taken after edge i.
    task automatic first_period(input string tag);
        clr_counts();
        for (int e = 1; e <= 2047; e++) begin
            tick();
            sample();
            if (e == 33)   check({tag, "_p1l_pre_rise"}, int'(PWM1_lft), 0);
            if (e == 34)   check({tag, "_p1l_rise"}, int'(PWM1_lft), 1);
            if (e == 2046) check({tag, "_synch_early"}, int'(PWM_synch), 0);
            if (e == 2047) check({tag, "_synch"}, int'(PWM_synch), 1);
        end
        check({tag, "_p1l_high"}, n_p1l, 992);
    endtask

    // One 2048-sample window; sample i sees cnt == i when aligned.
    // mode 0: no fault, 1: fault whole window, 2: fault only inside the
    // blanking windows, 3: fault only on the synch cycle.
    task automatic window(input int mode, input int chg_idx,
                          input logic [11:0] nl, input logic [11:0] nr);
        clr_counts();
        for (int i = 0; i < 2048; i++) begin
            tick();
            if (i == chg_idx) begin
                lft_spd  = nl;
                rght_spd = nr;
            end
            case (mode)
                1:       OVR_I_lft = 1'b1;
                2:       OVR_I_lft = ((i >= 3 && i <= 100) || (i >= 1028 && i <= 1100));
                3:       OVR_I_lft = (i == 2047);
                default: OVR_I_lft = 1'b0;
            endcase
            sample();
        end
    endtask

    initial begin
        rst = 1'b1; lft_spd = 12'd0; rght_spd = 12'h7FF;
        OVR_I_lft = 1'b0; OVR_I_rght = 1'b0;
        repeat (3) tick();
        check("rst_pwm", int'({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght}), 0);
        check("rst_synch", int'(PWM_synch), 0);
        check("rst_shtdwn", int'(OVR_I_shtdwn), 0);
        rst = 1'b0;

        first_period("p0");
        check("p0_synch_count", n_synch, 1);
        check("p0_p1r_high", n_p1r, 992);        // duty_q resets to 0x400

        window(0, -1, 12'd0, 12'd0);             // W1: lft mid-scale steady
        check("w1_p1l", n_p1l, 992);
        check("w1_p2l", n_p2l, 992);
        check("w1_lowl", n_lowl, 64);
        check("w1_synch", n_synch, 1);

        window(0, 300, 12'd512, 12'h800);        // W2: change mid-period
        check("w2_p1l_kept", n_p1l, 992);
        check("w2_p1r_clip_hi", n_p1r, 2015);
        check("w2_p2r_clip_hi", n_p2r, 0);

        window(0, -1, 12'd0, 12'd0);             // W3
        check("w3_p1l_updated", n_p1l, 1504);
        check("w3_p2l_updated", n_p2l, 480);
        check("w3_p2r_clip_lo", n_p2r, 2015);

        window(0, 300, 12'd0, 12'd0);            // W4
        check("w4_p1r_clip_lo", n_p1r, 0);
        check("w4_p2r_clip_lo", n_p2r, 2048);

        window(0, -1, 12'd0, 12'd0);             // W5 settle at mid-scale
        check("w5_p1l", n_p1l, 992);

        for (int k = 0; k < 3; k++) window(1, -1, 12'd0, 12'd0);
        check("oc3_no_shtdwn", int'(OVR_I_shtdwn), 0);
        window(0, -1, 12'd0, 12'd0);             // clean period clears count
        for (int k = 0; k < 3; k++) window(1, -1, 12'd0, 12'd0);
        check("oc_313_no_shtdwn", int'(OVR_I_shtdwn), 0);
        check("oc_313_p1l", n_p1l, 992);

        for (int k = 0; k < 4; k++) window(2, -1, 12'd0, 12'd0);
        check("blank_no_shtdwn", int'(OVR_I_shtdwn), 0);

        for (int k = 0; k < 3; k++) window(1, -1, 12'd0, 12'd0);
        check("oc_3of4_no_shtdwn", int'(OVR_I_shtdwn), 0);
        window(1, -1, 12'd0, 12'd0);
        check("oc_4th_synch_pre", int'(OVR_I_shtdwn), 0);
        check("oc_p2l_pre", int'(PWM2_lft), 1);
        tick();
        OVR_I_lft = 1'b0;
        check("oc_shtdwn_set", int'(OVR_I_shtdwn), 1);
        check("oc_pwm_off", int'({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght}), 0);

        window(0, -1, 12'd0, 12'd0);             // off-alignment, all must be 0
        check("shtdwn_pwm_count", n_p1l + n_p2l + n_p1r + n_p2r, 0);
        check("shtdwn_sticky", int'(OVR_I_shtdwn), 1);

        rst = 1'b1; lft_spd = 12'd512;
        repeat (3) tick();
        check("rst2_shtdwn", int'(OVR_I_shtdwn), 0);
        check("rst2_pwm", int'({PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght}), 0);
        rst = 1'b0;
        first_period("p_rst");                   // runs at 0x400, not 512

        for (int k = 0; k < 3; k++) window(3, -1, 12'd512, 12'd0);
        check("synch_fault_3", int'(OVR_I_shtdwn), 0);
        window(3, -1, 12'd512, 12'd0);
        check("synch_fault_pre", int'(OVR_I_shtdwn), 0);
        tick();
        OVR_I_lft = 1'b0;
        check("synch_fault_shtdwn", int'(OVR_I_shtdwn), 1);

        check("never_overlap", overlap, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
